multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified memory port, PC, IR and register file.
- Decodes the IR fields and drives `alu_control`/`alu_op` into the ALU (arithmetic mode or branch-compare mode), plus the mux selects and write enables for each instruction phase.
- Waits on a memory-ready handshake for fetch, load and store.

Parameters:
- RESET_STATE, 0 (FETCH), FSM state entered on reset; fixed at FETCH, exposed only for bench visibility.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR/OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rd1
- alu_src_b  out  2  00 = rd2, 01 = imm, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_op  out  1  ALU mode: 0 = arithmetic, 1 = branch compare
- alu_control  out  3  ALU function
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset (async, active-high): state = FETCH.
  - While reset is high, every output is 0.
  - The first FETCH cycle is the first cycle after reset deasserts.
- Defaults: every output is 0 in every state unless listed below.
- ALU arithmetic encodings: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- FETCH:
  - mem_read = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, ADD, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Next: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01, imm_src = 10, ADD (branch target into ALUOut).
  - Next by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
  - Any other opcode, or funct3 010/011 on a branch: illegal_instr = 1 for this cycle only, next = FETCH, no write issued.
- MEMADR:
  - alu_src_a = 10, alu_src_b = 01, ADD.
  - imm_src = 00 for load, 01 for store.
  - Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD: mem_read = 1, adr_src = 1, result_src = 00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next FETCH.
- MEMWRITE: mem_write = 1, adr_src = 1, result_src = 00. Hold until mem_ready, then FETCH.
- EXECUTER: alu_src_a = 10, alu_src_b = 00, alu_control decoded from funct3. Next ALUWB.
  - funct3 000 → ADD, or SUB when funct7b5 = 1
  - 010 → SLT
  - 110 → OR
  - 111 → AND
  - Other funct3 values are flagged illegal in DECODE.
- EXECUTEI: alu_src_a = 10, alu_src_b = 01, imm_src = 00. Same decode as EXECUTER except funct3 000 is always ADD. Next ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next FETCH.
- BRANCH:
  - alu_src_a = 10, alu_src_b = 00, alu_op = 1, alu_control = funct3, result_src = 00.
  - In branch mode the ALU result is 1 when the condition holds, so the branch is taken when zero = 0.
  - pc_write = ~zero, combinational from zero within this state.
  - Next FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, ADD, result_src = 00, pc_write = 1. Next ALUWB.
- Latency, FETCH to next FETCH with zero wait states:
  - load 5, store 4, R-type 4, I-type 4, branch 3, jal 4 cycles.
  - Each mem_ready-low cycle adds 1.
- Reset asserted mid-instruction aborts immediately: outputs go to 0 at once, no partial write completes.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Optional Feature:
- Macro: INSTRET_COUNTER_EN.
- Defined:
  - Adds output `instret`, 32 bits, reset to 0.
  - Increments by 1 on the clock edge that leaves ALUWB, MEMWB, BRANCH, or MEMWRITE with mem_ready = 1.
  - Illegal instructions are not counted.
  - Wraps 0xFFFFFFFF → 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset high for 3 cycles with mem_ready = 1 → all outputs 0. After release, FETCH shows pc_write = 1, ir_write = 1, alu_control = 000.
- R-type opcode 0110011, funct3 000, funct7b5 1 → EXECUTER drives alu_control = 001. reg_write pulses in cycle 4. Next FETCH is at cycle 5.
- Branch opcode 1100011, funct3 101, zero = 0 → in BRANCH: alu_op = 1, alu_control = 101, pc_write = 1. Same with zero = 1 → pc_write = 0.
- Load opcode 0000011 with mem_ready low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles, reg_write with result_src = 01 one cycle later.
- Opcode 1111111 → illegal_instr high for exactly 1 cycle in DECODE, no write enables asserted, returns to FETCH.
- With INSTRET_COUNTER_EN: run addi, sw, beq, then one illegal → instret = 3. Preload 0xFFFFFFFF and retire one instruction → instret = 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing the shared multicycle RV32I datapath.
// Define INSTRET_COUNTER_EN to add the 32-bit retired-instruction counter output instret.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       alu_op,
  output logic [2:0] alu_control,
  output logic       illegal_instr
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  state_t state_q, state_d;
  logic arith_f3_ok;
  logic [2:0] arith_ctl;
  always_comb begin
    arith_f3_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    arith_ctl = funct3 == 3'b010 ? ALU_SLT :
                funct3 == 3'b110 ? ALU_OR :
                funct3 == 3'b111 ? ALU_AND :
                (funct7b5 && state_q == EXECUTER) ? ALU_SUB : ALU_ADD;
  end
  always_comb begin
    state_d = state_q;
    {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src,
     alu_src_a, alu_src_b, imm_src, alu_op, alu_control, illegal_instr} = '0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R: state_d = arith_f3_ok ? EXECUTER : FETCH;
          OP_I: state_d = arith_f3_ok ? EXECUTEI : FETCH;
          OP_BRANCH: state_d = funct3[2:1] == 2'b01 ? FETCH : BRANCH;
          OP_JAL: state_d = JAL;
          default: state_d = FETCH;
        endcase
        // every decodable instruction leaves DECODE for a work state
        illegal_instr = state_d == FETCH;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = opcode[5] ? 2'b01 : 2'b00;
        state_d = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_control = arith_ctl;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = arith_ctl;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        // compare-mode ALU yields 1 when the condition holds, so taken means zero low
        alu_src_a = 2'b10;
        alu_op = 1'b1;
        alu_control = funct3;
        pc_write = ~zero;
        state_d = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
    if (reset)
      {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src,
       alu_src_a, alu_src_b, imm_src, alu_op, alu_control, illegal_instr} = '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= state_t'(RESET_STATE);
    else state_q <= state_d;
`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret_q, instret_d;
  logic retire;
  always_comb begin
    retire = state_q inside {ALUWB, MEMWB, BRANCH} || (state_q == MEMWRITE && mem_ready);
    instret_d = instret_q + {31'd0, retire};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) instret_q <= '0;
    else instret_q <= instret_d;
  assign instret = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table vectors, hand-written corner sequences and random
// instruction streams checked against a per-instruction phase model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, alu_op, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret;
`endif
  int total = 0, bad = 0, m_ret = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_op(alu_op), .alu_control(alu_control), .illegal_instr(illegal_instr)
`ifdef INSTRET_COUNTER_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic alu_op;
    logic [2:0] alu_control;
    logic illegal_instr;
  } ctl_t;
  typedef struct {
    logic mr, z;
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7;
    ctl_t c;
    string ph;
  } cyc_t;
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7, z;
    int lat;
    logic ill;
    logic [4:0] c3;
  } vec_t;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  cyc_t q[$];
  vec_t tbl[18];
  logic [6:0] g_opc;
  logic [2:0] g_f3;
  logic g_f7;

  function automatic ctl_t actual();
    return {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, imm_src, alu_op, alu_control, illegal_instr};
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic ctl_t fetch_ctl(input logic mr);
    ctl_t c;
    c = '0;
    c.mem_read = 1'b1;
    c.alu_src_b = 2'b10;
    c.result_src = 2'b10;
    c.pc_write = mr;
    c.ir_write = mr;
    return c;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic add(input logic mr, input logic z, input ctl_t c, input string ph);
    cyc_t r;
    r.mr = mr; r.z = z; r.opc = g_opc; r.f3 = g_f3; r.f7 = g_f7; r.c = c; r.ph = ph;
    q.push_back(r);
  endtask

  // Expands one instruction into its expected cycle-by-cycle control words.
  task automatic gen(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                     input logic z, input int wf, input int wm);
    ctl_t c;
    bit ld, st, rt, it, br, jl, legal;
    logic [2:0] ac;
    g_opc = opc; g_f3 = f3; g_f7 = f7;
    ld = opc == LD; st = opc == ST; rt = opc == RT; it = opc == IT; br = opc == BR; jl = opc == JL;
    legal = ld || st || jl || ((rt || it) && f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) ||
            (br && !(f3 inside {3'd2, 3'd3}));
    ac = f3 == 3'd0 ? ((rt && f7) ? 3'b001 : 3'b000) : f3 == 3'd2 ? 3'b101 :
         f3 == 3'd6 ? 3'b011 : 3'b010;
    for (int i = 0; i <= wf; i++) add(i == wf, rb(), fetch_ctl(i == wf), "fetch");
    c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 2'b10; c.illegal_instr = !legal;
    add(rb(), rb(), c, "decode");
    if (!legal) return;
    m_ret++;
    if (ld || st) begin
      c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.imm_src = st ? 2'b01 : 2'b00;
      add(rb(), rb(), c, "memadr");
      for (int i = 0; i <= wm; i++) begin
        c = '0; c.adr_src = 1'b1; c.mem_read = ld; c.mem_write = st;
        add(i == wm, rb(), c, ld ? "memread" : "memwrite");
      end
      if (ld) begin
        c = '0; c.result_src = 2'b01; c.reg_write = 1'b1;
        add(rb(), rb(), c, "memwb");
      end
    end else if (br) begin
      c = '0; c.alu_src_a = 2'b10; c.alu_op = 1'b1; c.alu_control = f3; c.pc_write = !z;
      add(rb(), z, c, "branch");
    end else begin
      c = '0;
      if (jl) begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
      end else begin
        c.alu_src_a = 2'b10; c.alu_src_b = it ? 2'b01 : 2'b00; c.alu_control = ac;
      end
      add(rb(), rb(), c, jl ? "jal" : "execute");
      c = '0; c.reg_write = 1'b1;
      add(rb(), rb(), c, "aluwb");
    end
  endtask

  task automatic run_q();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      opcode = r.opc; funct3 = r.f3; funct7b5 = r.f7; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      check(r.ph, actual(), r.c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset outputs", actual(), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    ctl_t c;
    tbl[0]  = '{RT, 3'd0, 1'b0, 1'b0, 4, 1'b0, 5'b00000};
    tbl[1]  = '{RT, 3'd0, 1'b1, 1'b0, 4, 1'b0, 5'b00010};
    tbl[2]  = '{RT, 3'd2, 1'b0, 1'b0, 4, 1'b0, 5'b01010};
    tbl[3]  = '{RT, 3'd6, 1'b0, 1'b1, 4, 1'b0, 5'b00110};
    tbl[4]  = '{RT, 3'd7, 1'b0, 1'b0, 4, 1'b0, 5'b00100};
    tbl[5]  = '{IT, 3'd0, 1'b1, 1'b0, 4, 1'b0, 5'b00000};
    tbl[6]  = '{IT, 3'd2, 1'b0, 1'b0, 4, 1'b0, 5'b01010};
    tbl[7]  = '{LD, 3'd2, 1'b0, 1'b0, 5, 1'b0, 5'b00000};
    tbl[8]  = '{ST, 3'd2, 1'b0, 1'b0, 4, 1'b0, 5'b00000};
    tbl[9]  = '{BR, 3'd0, 1'b0, 1'b0, 3, 1'b0, 5'b10001};
    tbl[10] = '{BR, 3'd5, 1'b0, 1'b1, 3, 1'b0, 5'b11010};
    tbl[11] = '{BR, 3'd1, 1'b0, 1'b0, 3, 1'b0, 5'b10011};
    tbl[12] = '{BR, 3'd2, 1'b0, 1'b0, 2, 1'b1, 5'b00001};
    tbl[13] = '{JL, 3'd0, 1'b0, 1'b0, 4, 1'b0, 5'b00001};
    tbl[14] = '{7'h7F, 3'd0, 1'b0, 1'b0, 2, 1'b1, 5'b00001};
    tbl[15] = '{RT, 3'd1, 1'b0, 1'b0, 2, 1'b1, 5'b00001};
    tbl[16] = '{IT, 3'd4, 1'b0, 1'b0, 2, 1'b1, 5'b00001};
    tbl[17] = '{BR, 3'd7, 1'b0, 1'b1, 3, 1'b0, 5'b11110};
    do_reset();
    @(negedge clk);
    check("fetch after reset", actual(), fetch_ctl(1'b1));
    #1 reset = 1'b1;
    #1 check("async reset in fetch", actual(), 0);
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      int n;
      bit done;
      logic ill2;
      logic [4:0] c3;
      opcode = tbl[k].opc; funct3 = tbl[k].f3; funct7b5 = tbl[k].f7; zero = tbl[k].z;
      mem_ready = 1'b1;
      n = 1; done = 0; ill2 = 1'b0; c3 = '0;
      while (!done && n < 12) begin
        @(posedge clk);
        #1 n++;
        @(negedge clk);
        if (n == 2) ill2 = illegal_instr;
        if (n == 3) c3 = {alu_op, alu_control, pc_write};
        done = ir_write;
      end
      check($sformatf("vec%0d latency", k), n - 1, tbl[k].lat);
      check($sformatf("vec%0d illegal", k), ill2, tbl[k].ill);
      check($sformatf("vec%0d cycle3 op/ctl/pcw", k), c3, tbl[k].c3);
    end
    do_reset();
    gen(LD, 3'd2, 1'b0, 1'b0, 0, 2);
    gen(7'h7F, 3'd0, 1'b0, 1'b0, 1, 0);
    gen(BR, 3'd5, 1'b0, 1'b0, 0, 0);
    gen(BR, 3'd5, 1'b0, 1'b1, 0, 0);
    run_q();
    opcode = ST; funct3 = 3'd2; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    c = '0; c.mem_write = 1'b1; c.adr_src = 1'b1;
    check("memwrite before abort", actual(), c);
    #1 reset = 1'b1;
    #1 check("abort mid store", actual(), 0);
    do_reset();
    for (int k = 0; k < 300; k++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = LD;
        1: o = ST;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JL;
        6: o = 7'h7F;
        default: o = 7'($urandom);
      endcase
      gen(o, 3'($urandom), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      run_q();
    end
`ifdef INSTRET_COUNTER_EN
    do_reset();
    check("instret reset", instret, 0);
    gen(IT, 3'd0, 1'b0, 1'b0, 0, 0);
    gen(ST, 3'd2, 1'b0, 1'b0, 0, 0);
    gen(BR, 3'd0, 1'b0, 1'b1, 0, 0);
    gen(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0);
    run_q();
    check("instret count", instret, 3);
    force dut.instret_q = 32'hFFFFFFFF;
    #1 release dut.instret_q;
    gen(IT, 3'd0, 1'b0, 1'b0, 0, 0);
    run_q();
    check("instret wrap", instret, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
